crc_sig_unload_checker: RTL and testbench

Downstream consumer of the 32-bit CRC/MISR signature register (polynomial x^32+x^16+x^11+x^4+1).
- Times a compaction window of programmable length.
- Captures the live signature, compares it against a golden value and flags pass/fail.
- Unloads the captured signature serially, MSB first, over a valid/ready handshake to the test-access logic.

---
 rtl/crc_sig_pkg.sv | 6 +
 rtl/crc_sig_unload_checker_sig_piso_shifter.sv | 34 +++
 rtl/crc_sig_unload_checker.sv | 75 +++++++
 tb/tb_crc_sig_unload_checker.sv | 104 ++++++++++
 4 files changed

// File: rtl/crc_sig_pkg.sv
// crc_sig_pkg: shared state encoding and constants for the CRC signature unload path
package crc_sig_pkg;
   localparam int SIG_W_DEF = 32;
   localparam logic [31:0] CRC_POLY = 32'h0001_0811;
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_CAPTURE, S_COMPARE, S_UNLOAD, S_DONE} state_t;
endpackage

// File: rtl/crc_sig_unload_checker_sig_piso_shifter.sv
// sig_piso_shifter: parallel-load shift register unloaded MSB first over valid/ready
module sig_piso_shifter
   import crc_sig_pkg::*;
#(
   parameter int W = SIG_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic         valid,
   input  logic         ready,
   input  logic [W-1:0] din,
   output logic         dout,
   output logic         last
);
   localparam int BW = $clog2(W);
   logic [W-1:0]  shift;
   logic [BW-1:0] bitcnt;
   logic          xfer;
   assign xfer = valid & ready;
   assign dout = shift[W-1];
   assign last = xfer && bitcnt == BW'(W - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shift  <= '0;
         bitcnt <= '0;
      end else if (load) shift <= din;
      else if (clear) bitcnt <= '0;
      else if (xfer) begin
         shift  <= {shift[W-2:0], 1'b0};
         bitcnt <= bitcnt + 1'b1;
      end
endmodule

// File: rtl/crc_sig_unload_checker.sv
// crc_sig_unload_checker: times a compaction window, checks the captured signature, unloads it serially
module crc_sig_unload_checker
   import crc_sig_pkg::*;
#(
   parameter int SIG_W = SIG_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic             CK,
   input  logic             RESET,
   input  logic             START,
   input  logic [CNT_W-1:0] WINDOW_LEN,
   input  logic [SIG_W-1:0] CRC_IN,
   input  logic [SIG_W-1:0] GOLDEN,
   input  logic             SO_READY,
   output logic             SO_VALID,
   output logic             SO_DATA,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic             FAIL,
   output logic [SIG_W-1:0] SIG_OUT
);
   state_t           state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [SIG_W-1:0] sig;
   logic             accept, last;
   assign accept   = START && state == S_IDLE;
   assign BUSY     = state != S_IDLE;
   assign DONE     = state == S_DONE;
   assign SO_VALID = state == S_UNLOAD;
   assign SIG_OUT  = sig;
   always_ff @(posedge CK or negedge RESET)
      if (!RESET) begin
         state <= S_IDLE;
         cnt   <= '0;
         sig   <= '0;
         PASS  <= 1'b0;
         FAIL  <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            cnt  <= WINDOW_LEN;
            sig  <= '0;
            PASS <= 1'b0;
            FAIL <= 1'b0;
         end else if (state == S_COUNT) cnt <= cnt - 1'b1;
         if (state == S_CAPTURE) sig <= CRC_IN;
         if (state == S_COMPARE) begin
            PASS <= sig == GOLDEN;
            FAIL <= sig != GOLDEN;
         end
      end
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    nxt = !START ? S_IDLE : (WINDOW_LEN == '0 ? S_CAPTURE : S_COUNT);
         S_COUNT:   nxt = cnt == CNT_W'(1) ? S_CAPTURE : S_COUNT;
         S_CAPTURE: nxt = S_COMPARE;
         S_COMPARE: nxt = S_UNLOAD;
         S_UNLOAD:  nxt = last ? S_DONE : S_UNLOAD;
         default:   nxt = S_IDLE;
      endcase
   end
   sig_piso_shifter #(.W(SIG_W)) u_piso (
      .clk  (CK),
      .rst_n(RESET),
      .load (state == S_CAPTURE),
      .clear(state == S_COMPARE),
      .valid(SO_VALID),
      .ready(SO_READY),
      .din  (CRC_IN),
      .dout (SO_DATA),
      .last (last)
   );
endmodule

// File: tb/tb_crc_sig_unload_checker.sv
// tb_crc_sig_unload_checker: table-driven and randomized runs against a transaction-level model
module tb_crc_sig_unload_checker;
   localparam int W = 32;
   logic          CK = 1'b0, RESET = 1'b1, START = 1'b0, SO_READY = 1'b0;
   logic          SO_VALID, SO_DATA, BUSY, DONE, PASS, FAIL;
   logic [15:0]   WINDOW_LEN = '0;
   logic [W-1:0]  CRC_IN = '0, GOLDEN = '0, SIG_OUT;
   int            errors = 0, checks = 0;
   typedef struct {
      int          w;
      logic [31:0] crc;
      logic [31:0] gold;
      int          rmode;
      int          abort;
   } vec_t;
   always #5 CK = ~CK;
   crc_sig_unload_checker dut (
      .CK(CK), .RESET(RESET), .START(START), .WINDOW_LEN(WINDOW_LEN), .CRC_IN(CRC_IN),
      .GOLDEN(GOLDEN), .SO_READY(SO_READY), .SO_VALID(SO_VALID), .SO_DATA(SO_DATA),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL(FAIL), .SIG_OUT(SIG_OUT)
   );
   function automatic logic [37:0] snap(input logic m);
      return {BUSY, SO_VALID, DONE, PASS, FAIL, SO_DATA & m, SIG_OUT};
   endfunction
   task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got busy/valid/done/pass/fail/data/sig=%h expected %h", name, act, exp);
      end
   endtask
   // Run one window; cycle 0 is the START cycle, unload begins w+3 cycles later.
   task automatic run_txn(input int id, input vec_t v);
      int          sent = 0, done_cyc = -1;
      bit          pe = (v.crc == v.gold), uv, ed, fin = 0;
      logic [37:0] exp;
      START = 1'b1; WINDOW_LEN = 16'(v.w);
      CRC_IN = $urandom; GOLDEN = $urandom; SO_READY = 1'($urandom);
      for (int cyc = 1; cyc < v.w + 400; cyc++) begin
         @(posedge CK); #1;
         uv  = cyc >= v.w + 3 && sent < W;
         ed  = cyc >= v.w + 3 && sent == W && done_cyc < 0;
         exp = {done_cyc < 0, uv, ed, cyc >= v.w + 3 && pe, cyc >= v.w + 3 && !pe,
                uv ? v.crc[W-1-sent] : 1'b0, cyc >= v.w + 2 ? v.crc : 32'h0};
         check($sformatf("run%0d cyc%0d", id, cyc), snap(uv), exp);
         if (done_cyc >= 0) begin
            fin = 1;
            break;
         end
         if (ed) done_cyc = cyc;
         if (v.abort > 0 && uv && sent == v.abort) begin
            #2 RESET = 1'b0;
            #1 check($sformatf("run%0d async reset", id), snap(1'b1), '0);
            @(posedge CK); #1;
            check($sformatf("run%0d reset held", id), snap(1'b1), '0);
            RESET = 1'b1; START = 1'b0;
            @(posedge CK); #1;
            check($sformatf("run%0d after reset", id), snap(1'b1), '0);
            return;
         end
         START      = 1'($urandom);
         WINDOW_LEN = 16'($urandom);
         CRC_IN     = cyc == v.w + 1 ? v.crc : $urandom;
         GOLDEN     = cyc == v.w + 2 ? v.gold : $urandom;
         SO_READY   = cyc < v.w + 3 ? 1'($urandom) : v.rmode == 0 ? 1'b1 :
                      v.rmode == 1 ? 1'((cyc - v.w - 3) % 3 == 0) : 1'($urandom);
         if (uv && SO_READY) sent++;
      end
      START = 1'b0;
      if (!fin) begin
         checks++; errors++;
         $display("FAIL run%0d timeout: sent=%0d expected %0d and DONE", id, sent, W);
      end
   endtask
   initial begin
      vec_t vecs[7];
      vec_t r;
      #2 RESET = 1'b0;
      #2 check("reset state", snap(1'b1), '0);
      @(posedge CK); #1;
      check("reset held", snap(1'b1), '0);
      RESET = 1'b1;
      @(posedge CK); #1;
      check("idle after release", snap(1'b1), '0);
      vecs = '{'{5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0},
               '{5, 32'hDEADBEEF, 32'hDEADBEEE, 0, 0},
               '{5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0},
               '{0, 32'h80000001, 32'h80000001, 0, 0},
               '{5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 10},
               '{5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0},
               '{1, 32'h12345678, 32'h00000000, 2, 0}};
      for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);
      for (int i = 0; i < 15; i++) begin
         r.w     = $urandom_range(0, 12);
         r.crc   = $urandom;
         r.gold  = $urandom_range(0, 1) == 1 ? r.crc : r.crc ^ (32'h1 << $urandom_range(0, 31));
         r.rmode = 2;
         r.abort = 0;
         run_txn(100 + i, r);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
